// File: rtl/wb_mailbox_slave_pkg.sv
// Shared register map, bit positions and bus state type for the Wishbone mailbox slave.
// Also holds the access legality check used by the bus decode.
package wb_mailbox_slave_pkg;

   localparam logic [7:0] REG_DATA    = 8'h00;
   localparam logic [7:0] REG_STATUS  = 8'h04;
   localparam logic [7:0] REG_CONTROL = 8'h08;
   localparam logic [7:0] REG_OUT     = 8'h0C;

   localparam int STAT_EMPTY_BIT = 9;
   localparam int STAT_FULL_BIT  = 10;
   localparam int STAT_OVF_BIT   = 11;
   localparam int STAT_UDF_BIT   = 12;

   localparam int CTRL_IRQ_EN_BIT = 0;
   localparam int CTRL_FLUSH_BIT  = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TERM = 1'b1
   } bus_state_t;

   // Misaligned, out-of-map, or a write to the read-only DATA register.
   function automatic logic access_error(input logic we, input logic [7:0] off);
      access_error = (off[1:0] != 2'b00) || (off > REG_OUT) || (we && (off == REG_DATA));
   endfunction

endpackage

// File: rtl/wb_mailbox_slave_if.sv
// Wishbone classic bus bundle between a bus master and the mailbox slave.
// cti/bte are carried but the slave treats every access as classic.
interface wb_mailbox_slave_if #(
   parameter int dw = 32,
   parameter int aw = 32
) ();

   logic          cyc;
   logic          stb;
   logic          we;
   logic [aw-1:0] adr;
   logic [dw-1:0] dat_w;
   logic [dw-1:0] dat_r;
   logic [3:0]    sel;
   logic [2:0]    cti;
   logic [1:0]    bte;
   logic          ack;
   logic          err;
   logic          rty;

   modport master (
      output cyc, stb, we, adr, dat_w, sel, cti, bte,
      input  dat_r, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel, cti, bte,
      output dat_r, ack, err, rty
   );

endinterface

// File: rtl/wb_mailbox_slave_fifo.sv
// Inbound mailbox FIFO: synchronous, power-of-two depth, with flush.
// A pop frees a slot for a push in the same cycle even when full.
module mbox_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop) && !flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_mailbox_slave.sv
// Wishbone classic mailbox slave: local producer fills a FIFO drained through DATA,
// plus STATUS/CONTROL registers, a bus-written outbound strobe and a level interrupt.
//
// state   | meaning
// ST_IDLE | no termination pending; a sampled cyc&&stb commits the access
// ST_TERM | ack or err driven for exactly this cycle
module wb_mailbox_slave
   import wb_mailbox_slave_pkg::*;
#(
   parameter int dw         = 32,
   parameter int aw         = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   wb_mailbox_slave_if.slave wb,
   input  logic              push_valid,
   input  logic [31:0]       push_data,
   output logic              push_ready,
   output logic [31:0]       out_data,
   output logic              out_valid,
   output logic              interrupt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   bus_state_t      state_q;
   bus_state_t      state_d;
   logic            go;
   logic            acc_err;
   logic            err_q;
   logic            wr_ok;
   logic            rd_ok;
   logic [7:0]      off;
   logic [dw-1:0]   rd_data_q;
   logic [31:0]     rd_mux;
   logic [31:0]     status_word;
   logic            irq_en;
   logic            ovf_q;
   logic            udf_q;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_flush;
   logic [31:0]     fifo_dout;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            overflow_evt;
   logic            underflow_evt;
   logic            unused_bits;

   assign off     = wb.adr[7:0];
   assign go      = (state_q == ST_IDLE) && wb.cyc && wb.stb;
   assign acc_err = access_error(wb.we, off);
   assign wr_ok   = go && !acc_err && wb.we;
   assign rd_ok   = go && !acc_err && !wb.we;

   assign fifo_pop      = rd_ok && (off == REG_DATA) && !fifo_empty;
   assign underflow_evt = rd_ok && (off == REG_DATA) && fifo_empty;
   assign fifo_flush    = wr_ok && (off == REG_CONTROL) && wb.sel[0] && wb.dat_w[CTRL_FLUSH_BIT];
   // A pop in the same cycle lets a push land even though push_ready is low.
   assign fifo_push     = push_valid && (!fifo_full || fifo_pop) && !fifo_flush;
   assign overflow_evt  = push_valid && fifo_full && !fifo_pop && !fifo_flush;
   assign push_ready    = !fifo_full && !wb_rst;

   mbox_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (wb_clk),
      .rst   (wb_rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (push_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge wb_clk) begin
      if (wb_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (wb.cyc && wb.stb) state_d = ST_TERM;
         ST_TERM: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (state_q == ST_TERM) begin
         wb.ack = !err_q;
         wb.err = err_q;
      end
   end

   assign wb.rty   = 1'b0;
   assign wb.dat_r = rd_data_q;

   always_comb begin
      status_word                 = '0;
      status_word[8:0]            = 9'(fifo_count);
      status_word[STAT_EMPTY_BIT] = fifo_empty;
      status_word[STAT_FULL_BIT]  = fifo_full;
      status_word[STAT_OVF_BIT]   = ovf_q;
      status_word[STAT_UDF_BIT]   = udf_q;
   end

   always_comb begin
      rd_mux = '0;
      case (off)
         REG_DATA:    rd_mux = fifo_empty ? 32'h0 : fifo_dout;
         REG_STATUS:  rd_mux = status_word;
         REG_CONTROL: rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
         REG_OUT:     rd_mux = out_data;
         default:     rd_mux = '0;
      endcase
   end

   // Side effects commit on the edge that raises the termination.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         err_q     <= 1'b0;
         rd_data_q <= '0;
         irq_en    <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         interrupt <= irq_en && !fifo_empty;
         if (go) begin
            err_q     <= acc_err;
            rd_data_q <= rd_ok ? rd_mux : '0;
         end
         if (wr_ok && (off == REG_CONTROL) && wb.sel[0]) irq_en <= wb.dat_w[CTRL_IRQ_EN_BIT];
         if (wr_ok && (off == REG_OUT)) begin
            for (int b = 0; b < 4; b++) begin
               if (wb.sel[b]) out_data[8*b +: 8] <= wb.dat_w[8*b +: 8];
            end
            out_valid <= 1'b1;
         end
         if (wr_ok && (off == REG_STATUS) && wb.sel[1]) begin
            if (wb.dat_w[STAT_OVF_BIT]) ovf_q <= 1'b0;
            if (wb.dat_w[STAT_UDF_BIT]) udf_q <= 1'b0;
         end
         // A new event in the same cycle as a clear keeps the flag set.
         if (overflow_evt)  ovf_q <= 1'b1;
         if (underflow_evt) udf_q <= 1'b1;
      end
   end

   assign unused_bits = ^{wb.cti, wb.bte, wb.adr[aw-1:8]};

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Self-checking bench for wb_mailbox_slave: constant vector table, directed corner
// sequences and a randomized run against a queue-based mailbox model.
module tb_wb_mailbox_slave;

   localparam int DEPTH = 16;
   localparam int NV    = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        interrupt;

   always #5 clk = ~clk;

   wb_mailbox_slave_if #(.dw(32), .aw(32)) bus ();

   wb_mailbox_slave #(.dw(32), .aw(32), .FIFO_DEPTH(DEPTH)) dut (
      .wb_clk     (clk),
      .wb_rst     (rst),
      .wb         (bus),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .interrupt  (interrupt)
   );

   int checks = 0;
   int errors = 0;

   // mailbox model: queue of pending words plus register state
   logic [31:0] mq[$];
   logic        m_ovf, m_udf, m_irq;
   logic [31:0] m_out;

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_outv;
   } vec_t;

   vec_t vecs[NV];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s       = '0;
      s[8:0]  = 9'(mq.size());
      s[9]    = (mq.size() == 0);
      s[10]   = (mq.size() == DEPTH);
      s[11]   = m_ovf;
      s[12]   = m_udf;
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_irq = 1'b0;
      m_out = '0;
   endtask

   task automatic model_access(input logic we, input logic [7:0] off, input logic [31:0] dat,
                               input logic [3:0] sel, input logic with_push, input logic [31:0] pdat,
                               output logic exp_err, output logic [31:0] exp_rd);
      logic popping, flushing, was_full;
      exp_rd   = '0;
      popping  = 1'b0;
      flushing = 1'b0;
      was_full = (mq.size() == DEPTH);
      exp_err  = (off % 4 != 0) || (off > 8'h0C) || (we && off == 8'h00);
      if (!exp_err && !we) begin
         case (off)
            8'h00: if (mq.size() == 0) m_udf = 1'b1; else begin exp_rd = mq[0]; popping = 1'b1; end
            8'h04: exp_rd = m_status();
            8'h08: exp_rd = {31'b0, m_irq};
            default: exp_rd = m_out;
         endcase
      end else if (!exp_err) begin
         case (off)
            8'h04: if (sel[1]) begin
               if (dat[11]) m_ovf = 1'b0;
               if (dat[12]) m_udf = 1'b0;
            end
            8'h08: if (sel[0]) begin m_irq = dat[0]; flushing = dat[1]; end
            default: for (int b = 0; b < 4; b++) if (sel[b]) m_out[8*b +: 8] = dat[8*b +: 8];
         endcase
      end
      if (popping)  void'(mq.pop_front());
      if (flushing) mq.delete();
      if (with_push && !flushing) begin
         if (!was_full || popping) mq.push_back(pdat);
         else m_ovf = 1'b1;
      end
   endtask

   // Enters and returns on a falling edge, with one idle cycle after the termination.
   task automatic bus_op(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic with_push, input logic [31:0] pdat,
                         output logic g_ack, output logic g_err, output logic [31:0] rdat,
                         output logic outv, output logic irq_ack, output int lat);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = {24'h0, adr};
      bus.dat_w = dat; bus.sel = sel;
      push_valid = with_push; push_data = pdat;
      g_ack = 1'b0; g_err = 1'b0; rdat = '0; outv = 1'b0; irq_ack = 1'b0; lat = 0;
      while (!(g_ack || g_err) && lat < 8) begin
         @(negedge clk);
         lat++;
         push_valid = 1'b0;
         if (bus.ack || bus.err) begin
            g_ack = bus.ack; g_err = bus.err; rdat = bus.dat_r;
            outv = out_valid; irq_ack = interrupt;
         end
      end
      if (!(g_ack || g_err)) lat = 99;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_op(input string name, input logic we, input logic [7:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic with_push, input logic [31:0] pdat,
                        output logic [31:0] rdat, output logic irq_ack);
      logic e_err, g_ack, g_err, outv, is_out;
      logic [31:0] e_rd;
      int lat;
      model_access(we, adr, dat, sel, with_push, pdat, e_err, e_rd);
      bus_op(we, adr, dat, sel, with_push, pdat, g_ack, g_err, rdat, outv, irq_ack, lat);
      is_out = we && !e_err && (adr == 8'h0C);
      check32({name, " latency"}, lat, 1);
      check1({name, " ack"}, g_ack, !e_err);
      check1({name, " err"}, g_err, e_err);
      if (!we && !e_err) check32({name, " rdata"}, rdat, e_rd);
      check1({name, " out_valid"}, outv, is_out);
      if (is_out) check32({name, " out_data"}, out_data, m_out);
      check1({name, " interrupt"}, interrupt, m_irq && (mq.size() != 0));
   endtask

   task automatic push_word(input logic [31:0] d, input string name);
      check1({name, " push_ready"}, push_ready, mq.size() < DEPTH);
      push_valid = 1'b1; push_data = d;
      @(negedge clk);
      push_valid = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] rd, e_rd;
   logic        ia, e_err, g_ack, g_err, outv;
   int          lat, r;
   logic [3:0]  pat;
   logic [7:0]  ra;

   initial begin
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_w = '0;
      bus.sel = '0; bus.cti = '0; bus.bte = '0;
      push_valid = 1'b0; push_data = '0;
      model_reset();

      vecs[0]  = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
      vecs[1]  = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,         1'b0};
      vecs[2]  = '{1'b1, 8'h08, 32'h1,        4'h1, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b0, 1'b1, 32'h1,         1'b0};
      vecs[4]  = '{1'b1, 8'h08, 32'h0,        4'h2, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[5]  = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b0, 1'b1, 32'h1,         1'b0};
      vecs[6]  = '{1'b1, 8'h08, 32'h0,        4'h1, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[7]  = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,         1'b0};
      vecs[8]  = '{1'b1, 8'h00, 32'h5,        4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
      vecs[9]  = '{1'b0, 8'h10, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
      vecs[10] = '{1'b1, 8'h0A, 32'h1,        4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
      vecs[11] = '{1'b1, 8'h02, 32'h1,        4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
      vecs[12] = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,         1'b0};
      vecs[13] = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,         1'b0};
      vecs[15] = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_1200, 1'b0};
      vecs[16] = '{1'b1, 8'h04, 32'h1000,     4'h1, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[17] = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_1200, 1'b0};
      vecs[18] = '{1'b1, 8'h04, 32'h1000,     4'h2, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[19] = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
      vecs[20] = '{1'b1, 8'h0C, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0,         1'b1};
      vecs[21] = '{1'b1, 8'h0C, 32'h00000011, 4'h1, 1'b0, 1'b0, 32'h0,         1'b1};
      vecs[22] = '{1'b0, 8'h0C, 32'h0,        4'hF, 1'b0, 1'b1, 32'hAABBCC11, 1'b0};
      vecs[23] = '{1'b0, 8'h0D, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,         1'b0};

      // reset
      repeat (3) @(negedge clk);
      check1("push_ready in reset", push_ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check1("reset ack", bus.ack, 1'b0);
      check1("reset err", bus.err, 1'b0);
      check32("reset dat_o", bus.dat_r, 32'h0);
      check1("reset push_ready", push_ready, 1'b1);
      check32("reset out_data", out_data, 32'h0);
      check1("reset out_valid", out_valid, 1'b0);
      check1("reset interrupt", interrupt, 1'b0);

      // constant vector table from reset state
      for (int i = 0; i < NV; i++) begin
         model_access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0, 32'h0, e_err, e_rd);
         bus_op(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0, 32'h0,
                g_ack, g_err, rd, outv, ia, lat);
         check32($sformatf("vec%0d latency", i), lat, 1);
         check1($sformatf("vec%0d ack", i), g_ack, !vecs[i].exp_err);
         check1($sformatf("vec%0d err", i), g_err, vecs[i].exp_err);
         if (vecs[i].chk_rd) check32($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         check1($sformatf("vec%0d out_valid", i), outv, vecs[i].exp_outv);
      end
      check32("vec out_data merged", out_data, 32'hAABBCC11);

      // two pushes, irq enable, two pops
      push_word(32'h11111111, "B push1");
      push_word(32'h22222222, "B push2");
      do_op("B irq enable", 1'b1, 8'h08, 32'h1, 4'h1, 1'b0, 32'h0, rd, ia);
      check1("B irq at enable ack", ia, 1'b0);
      check1("B irq after enable", interrupt, 1'b1);
      do_op("B pop1", 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("B pop1 word", rd, 32'h11111111);
      do_op("B pop2", 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("B pop2 word", rd, 32'h22222222);
      check1("B irq at last pop ack", ia, 1'b1);
      check1("B irq after last pop", interrupt, 1'b0);

      // overflow with push_valid forced
      for (int i = 0; i <= DEPTH; i++) push_word(32'h1000 + i, $sformatf("C push%0d", i));
      check1("C push_ready when full", push_ready, 1'b0);
      do_op("C status full", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("C status value", rd, 32'h0000_0C10);
      do_op("C clear ovf", 1'b1, 8'h04, 32'h800, 4'hF, 1'b0, 32'h0, rd, ia);
      do_op("C status cleared", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("C status after clear", rd, 32'h0000_0410);

      // simultaneous push and pop at full, then flush with a same-cycle push
      do_op("D push+pop", 1'b0, 8'h00, 32'h0, 4'hF, 1'b1, 32'hBEEF0001, rd, ia);
      check32("D oldest word", rd, 32'h0000_1000);
      do_op("D status", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("D status after push+pop", rd, 32'h0000_0410);
      do_op("D flush", 1'b1, 8'h08, 32'h3, 4'h1, 1'b1, 32'hBEEF0002, rd, ia);
      do_op("D status after flush", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("D flushed status", rd, 32'h0000_0200);
      do_op("D control", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("D control flush reads 0", rd, 32'h1);

      // strobe held across the ack: terminations at most every other cycle
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h4; bus.sel = 4'hF;
      pat = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pat = {pat[2:0], bus.ack};
      end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      @(negedge clk);
      check32("F back-to-back ack pattern", 32'(pat), 32'hA);

      // reset in the middle of an access
      push_word(32'hCAFE0000, "G push");
      do_op("G status", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0; rst = 1'b1;
      @(negedge clk);
      check1("G ack suppressed", bus.ack, 1'b0);
      check1("G err suppressed", bus.err, 1'b0);
      check1("G push_ready in reset", push_ready, 1'b0);
      check32("G out_data reset", out_data, 32'h0);
      check1("G interrupt reset", interrupt, 1'b0);
      rst = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
      @(negedge clk);
      model_reset();
      do_op("G status after reset", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("G status value", rd, 32'h0000_0200);
      do_op("G control after reset", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
      check32("G control value", rd, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2: push_word($urandom, $sformatf("R%0d push", i));
            3: do_op($sformatf("R%0d pop+push", i), 1'b0, 8'h00, 32'h0, 4'hF,
                     1'($urandom_range(0, 1)), $urandom, rd, ia);
            4: do_op($sformatf("R%0d pop", i), 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
            5: do_op($sformatf("R%0d status", i), 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
            6: do_op($sformatf("R%0d control", i), 1'b1, 8'h08,
                     {30'b0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))},
                     4'($urandom_range(0, 15)), 1'b0, 32'h0, rd, ia);
            7: do_op($sformatf("R%0d out", i), 1'b1, 8'h0C, $urandom,
                     4'($urandom_range(0, 15)), 1'b0, 32'h0, rd, ia);
            8: do_op($sformatf("R%0d w1c", i), 1'b1, 8'h04, $urandom & 32'h1800,
                     4'($urandom_range(0, 15)), 1'b0, 32'h0, rd, ia);
            default: begin
               ra = 8'($urandom_range(0, 19));
               do_op($sformatf("R%0d any adr %02h", i, ra), 1'($urandom_range(0, 1)), ra,
                     $urandom & 32'hFFFF_FFFD, 4'($urandom_range(0, 15)), 1'b0, 32'h0, rd, ia);
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
